// File: rtl/id_ex_alu_issue.sv
// ID-stage MIPS-I decoder plus ID/EX pipeline register feeding the EX-stage ALU.
// Optional feature: define ID_OVF_TRAP_EN to flag add/sub/addi for overflow trapping.
module id_ex_alu_issue #(
  parameter logic [4:0] NOP_CODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        id_hazard,
  output logic        ex_valid,
  output logic [4:0]  ex_alu_code,
  output logic [31:0] ex_op_a,
  output logic [31:0] ex_op_b,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_store_data,
  output logic        ex_illegal,
  output logic        ex_ovf_en
);

  typedef enum logic [4:0] {
    ALU_ADD, ALU_AND, ALU_XOR, ALU_OR, ALU_NOR, ALU_SUB, ALU_ANDI, ALU_XORI,
    ALU_ORI, ALU_JR, ALU_BEQ, ALU_BNE, ALU_BGEZ, ALU_BGTZ, ALU_BLEZ, ALU_BLTZ,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_code_e;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rdf, w_shamt;
  logic [31:0] w_sext, w_zext;

  assign w_op    = id_instr[31:26];
  assign w_rs    = id_instr[25:21];
  assign w_rt    = id_instr[20:16];
  assign w_rdf   = id_instr[15:11];
  assign w_shamt = id_instr[10:6];
  assign w_funct = id_instr[5:0];
  assign w_sext  = {{16{id_instr[15]}}, id_instr[15:0]};
  assign w_zext  = {16'h0, id_instr[15:0]};

  logic [4:0]  w_code, w_rd;
  logic [31:0] w_a, w_b, w_sd;
  logic        w_wr, w_mr, w_mw, w_ill, w_ovf, w_rt_src;

  always_comb begin
    w_code   = ALU_ADD;
    w_a      = id_rs_data;
    w_b      = id_rt_data;
    w_rd     = '0;
    w_wr     = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_ill    = 1'b0;
    w_rt_src = 1'b0;
    unique case (w_op)
      6'h00: begin
        w_rd     = w_rdf;
        w_wr     = 1'b1;
        w_rt_src = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_code = ALU_ADD;
          6'h22, 6'h23: w_code = ALU_SUB;
          6'h24: w_code = ALU_AND;
          6'h25: w_code = ALU_OR;
          6'h26: w_code = ALU_XOR;
          6'h27: w_code = ALU_NOR;
          6'h2A: w_code = ALU_SLT;
          6'h2B: w_code = ALU_SLTU;
          6'h08: begin w_code = ALU_JR; w_wr = 1'b0; end
          6'h00: begin w_code = ALU_SLL; w_a = {27'h0, w_shamt}; end
          6'h02: begin w_code = ALU_SRL; w_a = {27'h0, w_shamt}; end
          6'h03: begin w_code = ALU_SRA; w_a = {27'h0, w_shamt}; end
          6'h04: begin w_code = ALU_SLL; w_a = {27'h0, id_rs_data[4:0]}; end
          6'h06: begin w_code = ALU_SRL; w_a = {27'h0, id_rs_data[4:0]}; end
          6'h07: begin w_code = ALU_SRA; w_a = {27'h0, id_rs_data[4:0]}; end
          default: w_ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: begin w_code = ALU_ADD;  w_b = w_sext; w_rd = w_rt; w_wr = 1'b1; end
      6'h0A:        begin w_code = ALU_SLT;  w_b = w_sext; w_rd = w_rt; w_wr = 1'b1; end
      6'h0B:        begin w_code = ALU_SLTU; w_b = w_sext; w_rd = w_rt; w_wr = 1'b1; end
      6'h23: begin w_code = ALU_ADD; w_b = w_sext; w_rd = w_rt; w_wr = 1'b1; w_mr = 1'b1; end
      6'h2B: begin w_code = ALU_ADD; w_b = w_sext; w_rd = w_rt; w_mw = 1'b1; w_rt_src = 1'b1; end
      6'h0C: begin w_code = ALU_ANDI; w_b = w_zext; w_rd = w_rt; w_wr = 1'b1; end
      6'h0D: begin w_code = ALU_ORI;  w_b = w_zext; w_rd = w_rt; w_wr = 1'b1; end
      6'h0E: begin w_code = ALU_XORI; w_b = w_zext; w_rd = w_rt; w_wr = 1'b1; end
      6'h0F: begin
        w_code = ALU_ADD; w_a = '0; w_b = {id_instr[15:0], 16'h0}; w_rd = w_rt; w_wr = 1'b1;
      end
      6'h04: begin w_code = ALU_BEQ;  w_rt_src = 1'b1; end
      6'h05: begin w_code = ALU_BNE;  w_rt_src = 1'b1; end
      6'h06: begin w_code = ALU_BLEZ; w_b = '0; end
      6'h07: begin w_code = ALU_BGTZ; w_b = '0; end
      6'h01: begin
        w_b = '0;
        case (w_rt)
          5'd0:    w_code = ALU_BLTZ;
          5'd1:    w_code = ALU_BGEZ;
          default: w_ill  = 1'b1;
        endcase
      end
      default: w_ill = 1'b1;
    endcase
    // Illegal overrides whatever the partial decode above produced.
    if (w_ill) begin
      w_code = NOP_CODE;
      w_a    = '0;
      w_b    = '0;
      w_rd   = '0;
      w_wr   = 1'b0;
      w_mr   = 1'b0;
      w_mw   = 1'b0;
    end
    if (w_rd == 5'd0) w_wr = 1'b0;
  end

  assign w_sd = w_mw ? id_rt_data : '0;

`ifdef ID_OVF_TRAP_EN
  assign w_ovf = ((w_op == 6'h00) && ((w_funct == 6'h20) || (w_funct == 6'h22))) ||
                 (w_op == 6'h08);
`else
  assign w_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || flush || (!stall && !id_valid)) begin
      ex_valid      <= 1'b0;
      ex_alu_code   <= NOP_CODE;
      ex_op_a       <= '0;
      ex_op_b       <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_store_data <= '0;
      ex_illegal    <= 1'b0;
      ex_ovf_en     <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_alu_code   <= w_code;
      ex_op_a       <= w_a;
      ex_op_b       <= w_b;
      ex_rd         <= w_rd;
      ex_reg_write  <= w_wr;
      ex_mem_read   <= w_mr;
      ex_mem_write  <= w_mw;
      ex_store_data <= w_sd;
      ex_illegal    <= w_ill;
      ex_ovf_en     <= w_ovf;
    end
  end

  assign id_hazard = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
                     ((ex_rd == w_rs) || ((ex_rd == w_rt) && w_rt_src));

endmodule
